// File: rtl/arm_framer_pkg.sv
// Shared types and helpers for arm_framer: pad size, FSM states and
// occupancy encode/decode (3-bit field where 0 means 8 bytes).
package arm_framer_pkg;

  localparam int unsigned PAD_BYTES = 6;

  typedef enum logic [1:0] {
    StIdle,
    StBody,
    StExtra
  } state_e;

  function automatic logic [3:0] occ_decode(input logic [2:0] occ);
    return (occ == 3'd0) ? 4'd8 : {1'b0, occ};
  endfunction

  function automatic logic [2:0] occ_encode(input logic [3:0] nbytes);
    return nbytes[2:0];
  endfunction

  // Keeps the leading nbytes bytes (byte 0 sits in [63:56]).
  function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) mask[63-8*i -: 8] = 8'hff;
    end
    return mask;
  endfunction

endpackage

// File: rtl/arm_framer_oreg.sv
// One-entry AXI-Stream output register; holds its contents while stalled.
module arm_framer_oreg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [3:0]  in_user,
  input  logic        in_last,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [3:0]  out_user,
  output logic        out_last,
  input  logic        out_ready
);

  logic        valid_q;
  logic [63:0] data_q;
  logic [3:0]  user_q;
  logic        last_q;

  assign in_ready = ~valid_q | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      data_q  <= in_valid ? in_data : '0;
      user_q  <= in_valid ? in_user : '0;
      last_q  <= in_valid & in_last;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_user  = user_q;
  assign out_last  = last_q;

endmodule

// File: rtl/arm_framer.sv
// Strips the 6-byte head pad from MAC frames and repacks into 64-bit words.
// Define ARM_FRAMER_STATS_EN to enable the frame/runt statistics counters.
module arm_framer
  import arm_framer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [63:0]          s_axis_tdata,
  input  logic [3:0]           s_axis_tuser,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] runt_cnt
);

  state_e      state_q, state_d;
  logic [15:0] carry_q, carry_d;
  logic [1:0]  xocc_q, xocc_d;
  logic        xerr_q, xerr_d;

  logic        o_valid, o_last, oreg_ready, runt_inc, s_hs;
  logic [63:0] o_data, word;
  logic [3:0]  o_user, in_occ;

  assign in_occ = occ_decode(s_axis_tuser[2:0]);
  assign word   = {carry_q, s_axis_tdata[63:16]};

  // Gated by reset_n so the input is never ready while reset is held.
  assign s_axis_tready = reset_n & ((state_q == StIdle) | ((state_q == StBody) & oreg_ready));
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d  = state_q;
    carry_d  = carry_q;
    xocc_d   = xocc_q;
    xerr_d   = xerr_q;
    o_valid  = 1'b0;
    o_data   = '0;
    o_user   = '0;
    o_last   = 1'b0;
    runt_inc = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          carry_d = s_axis_tdata[15:0];
          if (!s_axis_tlast) begin
            state_d = StBody;
          end else if (in_occ <= 4'(PAD_BYTES)) begin
            runt_inc = 1'b1;
          end else begin
            state_d = StExtra;
            xocc_d  = 2'(in_occ - 4'(PAD_BYTES));
            xerr_d  = s_axis_tuser[3];
          end
        end
      end
      StBody: begin
        if (s_hs) begin
          o_valid = 1'b1;
          carry_d = s_axis_tdata[15:0];
          o_data  = word;
          if (s_axis_tlast && in_occ <= 4'(PAD_BYTES)) begin
            o_last  = 1'b1;
            o_data  = word & byte_mask(4'(in_occ + 4'd2));
            o_user  = {s_axis_tuser[3], occ_encode(4'(in_occ + 4'd2))};
            state_d = StIdle;
          end else if (s_axis_tlast) begin
            state_d = StExtra;
            xocc_d  = 2'(in_occ - 4'(PAD_BYTES));
            xerr_d  = s_axis_tuser[3];
          end
        end
      end
      StExtra: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_data  = {carry_q, 48'h0} & byte_mask({2'b00, xocc_q});
        o_user  = {xerr_q, occ_encode({2'b00, xocc_q})};
        if (oreg_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d  = StIdle;
      carry_d  = '0;
      o_valid  = 1'b0;
      runt_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      carry_q <= '0;
      xocc_q  <= '0;
      xerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      xocc_q  <= xocc_d;
      xerr_q  <= xerr_d;
    end
  end

  arm_framer_oreg u_oreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (o_valid),
    .in_ready  (oreg_ready),
    .in_data   (o_data),
    .in_user   (o_user),
    .in_last   (o_last),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_user  (m_axis_tuser),
    .out_last  (m_axis_tlast),
    .out_ready (m_axis_tready)
  );

`ifdef ARM_FRAMER_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q, runt_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      runt_cnt_q  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (runt_inc) runt_cnt_q <= runt_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign runt_cnt  = runt_cnt_q;
`else
  logic unused_runt_inc;
  assign unused_runt_inc = runt_inc;
  assign frame_cnt       = {CNT_WIDTH{1'b0}};
  assign runt_cnt        = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_arm_framer.sv
// Self-checking bench for arm_framer: directed frames plus random traffic
// compared against a byte-level reference model.
module tb_arm_framer;

  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset_n, clear;
  logic [63:0]   s_tdata, m_tdata;
  logic [3:0]    s_tuser, m_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic          m_tlast, m_tvalid, m_tready;
  logic [CW-1:0] frame_cnt, runt_cnt;

  always #5 clk = ~clk;

  arm_framer #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clear),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_cnt     (frame_cnt),
    .runt_cnt      (runt_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        last;
    logic [3:0]  user;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          exp_frames = 0;
  int          exp_runts  = 0;
  int          bubble_mode = 0;  // 0 none, 1 after every word, 2 random
  int          rdy_mode    = 0;  // 0 always ready, 1 toggle, 2 random
  logic [63:0] fw[$];

  // Reference: flatten to bytes, drop the 6 pad bytes, repack 8 per word.
  task automatic model_frame(input logic [63:0] words[$], input logic [3:0] lu, input bit complete);
    logic [7:0] bytes[$];
    int occ, nb, n;
    beat_t b;
    occ = (lu[2:0] == 3'd0) ? 8 : int'(lu[2:0]);
    for (int i = 0; i < words.size(); i++) begin
      nb = (complete && i == words.size() - 1) ? occ : 8;
      for (int k = 0; k < nb; k++) bytes.push_back(words[i][63-8*k -: 8]);
    end
    if (bytes.size() <= 6) begin
      if (complete) exp_runts++;
      return;
    end
    repeat (6) void'(bytes.pop_front());
    while (bytes.size() > 0) begin
      if (!complete && bytes.size() < 8) break;
      b = '0;
      n = 0;
      while (n < 8 && bytes.size() > 0) begin
        b.data[63-8*n -: 8] = bytes.pop_front();
        n++;
      end
      b.last = complete && (bytes.size() == 0);
      b.user = b.last ? {lu[3], 3'(n % 8)} : 4'h0;
      exp_q.push_back(b);
    end
    if (complete) exp_frames++;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [3:0] u, input logic l);
    bit hs;
    int n;
    hs = 0;
    n  = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("s_handshake_timeout", 128'(hs), 128'(1));
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    if (bubble_mode == 1 || (bubble_mode == 2 && $urandom_range(0, 3) == 0)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [63:0] words[$], input logic [3:0] lu);
    model_frame(words, lu, 1'b1);
    for (int i = 0; i < words.size(); i++) begin
      if (i == words.size() - 1) send_word(words[i], lu, 1'b1);
      else send_word(words[i], 4'($urandom), 1'b0);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef ARM_FRAMER_STATS_EN
    check({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_frames));
    check({tag, "_runt_cnt"}, 128'(runt_cnt), 128'(exp_runts));
`else
    check({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(0));
    check({tag, "_runt_cnt"}, 128'(runt_cnt), 128'(0));
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check_counters(tag);
  endtask

  task automatic plan_frame(input logic [3:0] lu);
    fw.delete();
    for (int i = 0; i < 9; i++) fw.push_back(64'h1111111111111111 * 64'(i));
    fw.push_back(64'h9999999999999999);
    send_frame(fw, lu);
  endtask

  task automatic cut_words();
    fw.delete();
    for (int i = 0; i < 4; i++) fw.push_back({$urandom, $urandom});
  endtask

  // Output monitor: every accepted beat must match the model, stalls must hold.
  beat_t prev_beat;
  bit    prev_stall = 0;
  always @(negedge clk) begin
    beat_t cur;
    cur = {m_tlast, m_tuser, m_tdata};
    if (reset_n) begin
      if (prev_stall) check("stall_hold", 128'({m_tvalid, cur}), 128'({1'b1, prev_beat}));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 128'(0), 128'(1));
        else check("out_beat", 128'(cur), 128'(exp_q.pop_front()));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = cur;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    #1;
    check("reset_outputs", 128'({m_tvalid, m_tlast, m_tuser, m_tdata}), 128'(0));
    check("reset_s_tready", 128'(s_tready), 128'(0));
    check_counters("reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("post_reset_s_tready", 128'(s_tready), 128'(1));

    // Directed frames.
    plan_frame(4'h1);
    drain("plan_occ1");
    plan_frame(4'h0);
    drain("plan_occ8");
    bubble_mode = 1;
    plan_frame(4'h1);
    bubble_mode = 0;
    rdy_mode    = 1;
    plan_frame(4'h1);
    drain("b2b");
    rdy_mode = 0;
    fw.delete();
    fw.push_back(64'h0123456789abcdef);
    send_frame(fw, 4'h5);
    drain("runt");
    plan_frame(4'h9);
    drain("err_flag");

    // Random traffic with bubbles and backpressure.
    bubble_mode = 2;
    rdy_mode    = 2;
    for (int f = 0; f < 40; f++) begin
      fw.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) fw.push_back({$urandom, $urandom});
      send_frame(fw, 4'($urandom));
    end
    drain("random");

    // Reset in the middle of a frame: only already-handshaked words survive.
    bubble_mode = 0;
    rdy_mode    = 0;
    m_tready    = 1'b1;
    cut_words();
    model_frame(fw[0:2], 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(fw[i], 4'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", 128'({m_tvalid, m_tlast, m_tuser, m_tdata, s_tready}), 128'(0));
    check("midreset_delivered", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    exp_frames = 0;
    exp_runts  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    plan_frame(4'h1);
    drain("after_reset");

    // Clear in the middle of a frame, with a colliding input word.
    cut_words();
    model_frame(fw, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(fw[i], 4'h0, 1'b0);
    clear    = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 64'hdeadbeefcafef00d;
    s_tuser  = 4'h0;
    s_tlast  = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    check("clear_drops_valid", 128'(m_tvalid), 128'(0));
    plan_frame(4'h0);
    drain("after_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
